// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the single-cycle RV32I core.
// Combinational reads, clocked writes, 64-bit cycle/instret counters,
// trap/mret bookkeeping for mepc/mcause/mtval/mstatus.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr,
  input  logic        csr_we,
  input  logic [11:0] csr_rd_addr,
  input  logic [31:0] csr_wr_data,
  output logic [31:0] csr_rd_data,
  output logic        csr_illegal,
  input  logic        instr_retire,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        mstatus_mie
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL      = 32'h4000_0100;
  localparam logic [31:0] MTVEC_RST_VAL = {MTVEC_RESET[31:2], 2'b00};

  logic        mie_reg;
  logic        mpie_reg;
  logic [31:0] mtvec_reg;
  logic [31:0] mscratch_reg;
  logic [31:0] mepc_reg;
  logic [31:0] mcause_reg;
  logic [31:0] mtval_reg;
  logic [63:0] cnt_val [2];   // [0] = mcycle, [1] = minstret

  logic [31:0] mstatus_val;
  logic        implemented;
  logic        read_only;
  logic        wr_en;

  // MPP is hardwired to machine mode; only MIE and MPIE carry state.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_reg, 3'b0, mie_reg, 3'b0};

  // Address decode: read mux plus implemented/read-only classification.
  always_comb begin
    csr_rd_data = 32'h0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_rd_addr)
      A_MSTATUS:   csr_rd_data = mstatus_val;
      A_MISA:      begin csr_rd_data = MISA_VAL;            read_only = 1'b1; end
      A_MTVEC:     csr_rd_data = mtvec_reg;
      A_MSCRATCH:  csr_rd_data = mscratch_reg;
      A_MEPC:      csr_rd_data = mepc_reg;
      A_MCAUSE:    csr_rd_data = mcause_reg;
      A_MTVAL:     csr_rd_data = mtval_reg;
      A_MCYCLE:    csr_rd_data = cnt_val[0][31:0];
      A_MCYCLEH:   csr_rd_data = cnt_val[0][63:32];
      A_MINSTRET:  csr_rd_data = cnt_val[1][31:0];
      A_MINSTRETH: csr_rd_data = cnt_val[1][63:32];
      A_CYCLE:     begin csr_rd_data = cnt_val[0][31:0];    read_only = 1'b1; end
      A_CYCLEH:    begin csr_rd_data = cnt_val[0][63:32];   read_only = 1'b1; end
      A_INSTRET:   begin csr_rd_data = cnt_val[1][31:0];    read_only = 1'b1; end
      A_INSTRETH:  begin csr_rd_data = cnt_val[1][63:32];   read_only = 1'b1; end
      A_MHARTID:   begin csr_rd_data = HART_ID;             read_only = 1'b1; end
      default:     implemented = 1'b0;
    endcase
  end

  assign csr_illegal = csr & (~implemented | (csr_we & read_only));

  // A write only lands when it is legal and no trap/mret owns this edge.
  assign wr_en = csr & csr_we & implemented & ~read_only & ~trap & ~mret;

  // Trap state and software-visible registers: trap > mret > CSR write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mie_reg      <= 1'b0;
      mpie_reg     <= 1'b0;
      mtvec_reg    <= MTVEC_RST_VAL;
      mscratch_reg <= 32'h0;
      mepc_reg     <= 32'h0;
      mcause_reg   <= 32'h0;
      mtval_reg    <= 32'h0;
    end else if (trap) begin
      mepc_reg   <= {trap_pc[31:2], 2'b00};
      mcause_reg <= trap_cause;
      mtval_reg  <= trap_val;
      mpie_reg   <= mie_reg;
      mie_reg    <= 1'b0;
    end else if (mret) begin
      mie_reg  <= mpie_reg;
      mpie_reg <= 1'b1;
    end else if (wr_en) begin
      case (csr_rd_addr)
        A_MSTATUS:  begin mie_reg <= csr_wr_data[3]; mpie_reg <= csr_wr_data[7]; end
        A_MTVEC:    mtvec_reg    <= {csr_wr_data[31:2], 2'b00};
        A_MSCRATCH: mscratch_reg <= csr_wr_data;
        A_MEPC:     mepc_reg     <= {csr_wr_data[31:2], 2'b00};
        A_MCAUSE:   mcause_reg   <= csr_wr_data;
        A_MTVAL:    mtval_reg    <= csr_wr_data;
        default:    ;
      endcase
    end
  end

  // The two 64-bit counters share one structure; only the increment
  // condition and the address pair differ.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      localparam logic [11:0] LO_ADDR = (gi == 0) ? A_MCYCLE : A_MINSTRET;
      localparam logic [11:0] HI_ADDR = LO_ADDR | 12'h080;

      logic [63:0] cnt_reg;
      logic        inc;
      logic        wr_lo;
      logic        wr_hi;

      assign inc   = (gi == 0) ? 1'b1 : instr_retire;
      assign wr_lo = wr_en & (csr_rd_addr == LO_ADDR);
      assign wr_hi = wr_en & (csr_rd_addr == HI_ADDR);

      // A write to either half replaces it and blocks that edge's increment.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          cnt_reg <= 64'h0;
        else if (wr_lo)
          cnt_reg[31:0] <= csr_wr_data;
        else if (wr_hi)
          cnt_reg[63:32] <= csr_wr_data;
        else if (inc)
          cnt_reg <= cnt_reg + 64'd1;
      end

      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign mtvec       = mtvec_reg;
  assign mepc        = mepc_reg;
  assign mstatus_mie = mie_reg;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed plus randomized checking of csr_file against a
// behavioural model kept as plain variables and 64-bit integers.
module tb_csr_file;

  localparam logic [31:0] MTVEC_RESET = 32'h0000_0000;
  localparam logic [31:0] HART_ID     = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr;
  logic        csr_we;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;
  logic        csr_illegal;
  logic        instr_retire;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_val;
  logic        mret;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        mstatus_mie;

  csr_file #(.MTVEC_RESET(MTVEC_RESET), .HART_ID(HART_ID)) dut (
    .clk(clk), .reset(reset), .csr(csr), .csr_we(csr_we),
    .csr_rd_addr(csr_rd_addr), .csr_wr_data(csr_wr_data),
    .csr_rd_data(csr_rd_data), .csr_illegal(csr_illegal),
    .instr_retire(instr_retire), .trap(trap), .trap_pc(trap_pc),
    .trap_cause(trap_cause), .trap_val(trap_val), .mret(mret),
    .mtvec(mtvec), .mepc(mepc), .mstatus_mie(mstatus_mie)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  bit   [63:0] m_cyc, m_ins;

  logic [31:0] obs_rd;
  logic        obs_ill;

  logic [11:0] addr_tab [20] = '{
    12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
    12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
    12'hC82, 12'hF14, 12'h7C0, 12'h344, 12'hB01, 12'h000
  };

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = MTVEC_RESET & ~32'h3;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cyc = 0; m_ins = 0;
  endtask

  // Expected read value and classification of an address.
  function automatic void mread(input logic [11:0] a, output logic [31:0] v,
                                output bit legal, output bit ro);
    legal = 1; ro = 0; v = 0;
    case (a)
      12'h300: v = 32'h1800 + (m_mpie ? 32'd128 : 32'd0) + (m_mie ? 32'd8 : 32'd0);
      12'h301: begin v = 32'h4000_0100; ro = 1; end
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ins[31:0];
      12'hB82: v = m_ins[63:32];
      12'hC00: begin v = m_cyc[31:0];  ro = 1; end
      12'hC80: begin v = m_cyc[63:32]; ro = 1; end
      12'hC02: begin v = m_ins[31:0];  ro = 1; end
      12'hC82: begin v = m_ins[63:32]; ro = 1; end
      12'hF14: begin v = HART_ID; ro = 1; end
      default: legal = 0;
    endcase
  endfunction

  // Advance the model by one clock edge.
  task automatic model_edge(input bit c, input bit we, input logic [11:0] a,
                            input logic [31:0] wd, input bit ret, input bit tr,
                            input logic [31:0] tpc, input logic [31:0] tc,
                            input logic [31:0] tv, input bit mr);
    logic [31:0] v;
    bit legal, ro, do_wr;
    bit [63:0] cyc_n, ins_n;
    mread(a, v, legal, ro);
    do_wr = c && we && legal && !ro && !tr && !mr;
    cyc_n = m_cyc + 64'd1;
    ins_n = m_ins + (ret ? 64'd1 : 64'd0);
    if (do_wr) begin
      case (a)
        12'hB00: cyc_n = {m_cyc[63:32], wd};
        12'hB80: cyc_n = {wd, m_cyc[31:0]};
        12'hB02: ins_n = {m_ins[63:32], wd};
        12'hB82: ins_n = {wd, m_ins[31:0]};
        default: ;
      endcase
    end
    if (tr) begin
      m_mepc = tpc & ~32'h3; m_mcause = tc; m_mtval = tv;
      m_mpie = m_mie; m_mie = 0;
    end else if (mr) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (do_wr) begin
      case (a)
        12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
        12'h305: m_mtvec = wd & ~32'h3;
        12'h340: m_mscratch = wd;
        12'h341: m_mepc = wd & ~32'h3;
        12'h342: m_mcause = wd;
        12'h343: m_mtval = wd;
        default: ;
      endcase
    end
    m_cyc = cyc_n;
    m_ins = ins_n;
  endtask

  // One bus cycle: entered and left on a falling edge.
  task automatic step(input bit c, input bit we, input logic [11:0] a,
                      input logic [31:0] wd, input bit ret = 0, input bit tr = 0,
                      input logic [31:0] tpc = 0, input logic [31:0] tc = 0,
                      input logic [31:0] tv = 0, input bit mr = 0);
    logic [31:0] ev;
    bit legal, ro;
    csr = c; csr_we = we; csr_rd_addr = a; csr_wr_data = wd;
    instr_retire = ret; trap = tr; trap_pc = tpc; trap_cause = tc;
    trap_val = tv; mret = mr;
    #1;
    mread(a, ev, legal, ro);
    check_eq("rd_data", csr_rd_data, ev);
    check_eq("illegal", csr_illegal, c && (!legal || (we && ro)));
    check_eq("mtvec", mtvec, m_mtvec);
    check_eq("mepc", mepc, m_mepc);
    check_eq("mie", mstatus_mie, m_mie);
    obs_rd = csr_rd_data;
    obs_ill = csr_illegal;
    $display("txn addr=%h csr=%0d we=%0d wd=%h trap=%0d mret=%0d rd=%h ill=%0d",
             a, c, we, wd, tr, mr, obs_rd, obs_ill);
    @(posedge clk);
    model_edge(c, we, a, wd, ret, tr, tpc, tc, tv, mr);
    @(negedge clk);
  endtask

  logic [31:0] cyc_snap;

  initial begin
    reset = 0; csr = 0; csr_we = 0; csr_rd_addr = 0; csr_wr_data = 0;
    instr_retire = 0; trap = 0; trap_pc = 0; trap_cause = 0; trap_val = 0; mret = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;

    // Reset state and first counter values
    step(1, 0, 12'hB00, 0); check_eq("mcycle_first", obs_rd, 32'h0);
    step(1, 0, 12'hB00, 0); check_eq("mcycle_second", obs_rd, 32'h1);
    step(1, 0, 12'h300, 0); check_eq("rst_mstatus", obs_rd, 32'h0000_1800);
    step(1, 0, 12'h305, 0); check_eq("rst_mtvec", obs_rd, MTVEC_RESET & ~32'h3);
    step(1, 0, 12'h301, 0); check_eq("misa", obs_rd, 32'h4000_0100);

    // Write/read with masking
    step(1, 1, 12'h340, 32'hDEAD_BEEF); check_eq("mscratch_old", obs_rd, 32'h0);
    step(1, 0, 12'h340, 0);             check_eq("mscratch_new", obs_rd, 32'hDEAD_BEEF);
    step(1, 1, 12'h305, 32'h8000_0103);
    step(1, 0, 12'h305, 0);             check_eq("mtvec_mask", obs_rd, 32'h8000_0100);

    // Counter carry and write override
    step(1, 1, 12'hB00, 32'hFFFF_FFFF);
    step(1, 1, 12'hB80, 32'h0);
    step(1, 0, 12'hB00, 0); check_eq("carry_lo0", obs_rd, 32'hFFFF_FFFF);
    step(1, 0, 12'hB80, 0); check_eq("carry_hi", obs_rd, 32'h1);
    step(1, 0, 12'hB00, 0); check_eq("carry_lo1", obs_rd, 32'h1);
    step(1, 1, 12'hB02, 32'h1234_5678, 1);
    step(1, 0, 12'hB02, 0); check_eq("minstret_wr", obs_rd, 32'h1234_5678);

    // 64-bit wrap
    step(1, 1, 12'hB80, 32'hFFFF_FFFF);
    step(1, 1, 12'hB00, 32'hFFFF_FFFF);
    step(1, 0, 12'hB80, 0); check_eq("wrap_pre", obs_rd, 32'hFFFF_FFFF);
    step(1, 0, 12'hB80, 0); check_eq("wrap_hi", obs_rd, 32'h0);

    // Trap then mret; CSR write in the trap cycle is lost
    step(1, 1, 12'h300, 32'h0000_0008);
    step(1, 0, 12'h300, 0); check_eq("mie_set", obs_rd, 32'h0000_1808);
    step(1, 1, 12'h341, 32'h0000_0ABC, 0, 1, 32'h0000_0046, 32'd2, 32'h0);
    check_eq("trap_ill", obs_ill, 1'b0);
    step(1, 0, 12'h341, 0); check_eq("trap_mepc", obs_rd, 32'h44);
    step(1, 0, 12'h342, 0); check_eq("trap_mcause", obs_rd, 32'd2);
    step(1, 0, 12'h300, 0); check_eq("trap_mstatus", obs_rd, 32'h0000_1880);
    step(0, 0, 12'h300, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 12'h300, 0); check_eq("mret_mstatus", obs_rd, 32'h0000_1888);

    // Illegal access
    step(1, 0, 12'h7C0, 0); check_eq("ill_rd", obs_rd, 32'h0);
    check_eq("ill_flag", obs_ill, 1'b1);
    step(1, 0, 12'hC00, 0); cyc_snap = obs_rd;
    step(1, 1, 12'hC00, 32'h5555_0000); check_eq("ro_wr_ill", obs_ill, 1'b1);
    step(1, 0, 12'hB00, 0); check_eq("ro_wr_cycle", obs_rd, cyc_snap + 32'd2);
    step(1, 0, 12'hF14, 0); check_eq("mhartid", obs_rd, HART_ID);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           addr_tab[$urandom_range(0, 19)], $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom, $urandom, $urandom,
           $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset mid-cycle after writes
    step(1, 1, 12'h340, 32'hCAFE_F00D);
    step(1, 1, 12'h341, 32'h0000_1234);
    step(1, 1, 12'h300, 32'h0000_0088);
    csr = 1; csr_we = 0; trap = 0; mret = 0; instr_retire = 0;
    csr_rd_addr = 12'h340;
    #2 reset = 0;
    model_reset();
    #1 check_eq("async_mscratch", csr_rd_data, 32'h0);
    check_eq("async_mepc", mepc, 32'h0);
    check_eq("async_mie", mstatus_mie, 1'b0);
    check_eq("async_mtvec", mtvec, MTVEC_RESET & ~32'h3);
    csr_rd_addr = 12'h300;
    #1 check_eq("async_mstatus", csr_rd_data, 32'h0000_1800);
    csr_rd_addr = 12'hB00;
    #1 check_eq("async_mcycle", csr_rd_data, 32'h0);
    @(negedge clk);
    reset = 1;
    step(1, 0, 12'hB00, 0); check_eq("post_rst_mcycle", obs_rd, 32'h0);
    step(1, 0, 12'h341, 0); check_eq("post_rst_mepc", obs_rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_file.md
# csr_file

Machine-mode control and status register file for the single-cycle RV32I core: the responder on the core's CSR access port. It serves combinational reads and clocked writes, maintains the 64-bit cycle and retired-instruction counters, and records trap state (mepc/mcause/mtval/mstatus). It exports mtvec, mepc and mstatus.MIE to the PC/hardware-control logic.

## Interface
- MTVEC_RESET, 32'h0000_0000, mtvec value after reset; bits [1:0] ignored (forced 0).
- HART_ID, 0, value returned by mhartid.
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears state immediately while low.
- csr  input  1  CSR instruction in the current cycle.
- csr_we  input  1  write enable; qualified by csr. Core drops it for csrrs/csrrc with rs1 = x0.
- csr_rd_addr  input  12  CSR address (instr[31:20]); used for both read and write.
- csr_wr_data  input  32  final value to write; the core has already applied the set/clear operation.
- csr_rd_data  output  32  current value of the addressed CSR; combinational.
- csr_illegal  output  1  combinational. Asserted when csr=1 and the address is unimplemented, or when csr_we=1 targets a read-only CSR.
- instr_retire  input  1  one instruction retires this cycle.
- trap  input  1  take a trap this cycle.
- trap_pc  input  32  PC of the trapping instruction.
- trap_cause  input  32  mcause value for the trap.
- trap_val  input  32  mtval value for the trap.
- mret  input  1  return from trap this cycle.
- mtvec  output  32  current mtvec.
- mepc  output  32  current mepc.
- mstatus_mie  output  1  mstatus bit 3.

## Operation
Implemented CSRs and their reset values:
- mstatus 0x300: reset 32'h0000_1800.
  - Writable: MIE [3] and MPIE [7].
  - MPP [12:11] is hardwired to 2'b11.
  - All other bits read 0.
- misa 0x301: read-only, 32'h4000_0100.
- mtvec 0x305: reset MTVEC_RESET with [1:0] = 0. Direct mode only; writes force [1:0] = 0.
- mscratch 0x340: reset 0; full 32-bit read/write.
- mepc 0x341: reset 0; writes force [1:0] = 0.
- mcause 0x342: reset 0; full 32-bit read/write.
- mtval 0x343: reset 0; full 32-bit read/write.
- mcycle 0xB00 / mcycleh 0xB80: reset 0; read/write.
- minstret 0xB02 / minstreth 0xB82: reset 0; read/write.
- cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only shadows of the machine counters.
- mhartid 0xF14: read-only, HART_ID.

Reads:
- Any address not listed reads 0 and asserts csr_illegal.
- A write to a read-only or unimplemented address is dropped, with csr_illegal=1.

Counters:
- mcycle (64-bit) increments every cycle out of reset.
- minstret (64-bit) increments when instr_retire=1.
- Both wrap from 2^64-1 to 0.
- A CSR write to either 32-bit half replaces that half, and the whole counter does not increment that cycle.

Trap and return:
- trap=1:
  - mepc ← trap_pc & ~3
  - mcause ← trap_cause
  - mtval ← trap_val
  - MPIE ← MIE, then MIE ← 0
- mret=1: MIE ← MPIE, MPIE ← 1.

Priority for the same edge:
- reset > trap > mret > CSR write.
- A suppressed CSR write is lost and csr_illegal is not raised for it.
- Counters still increment when a trap or mret occurs.

## Timing
- Reads are combinational. csr_rd_data reflects the state before this cycle's edge, so a csrrw returns the old value.
- Writes, trap updates and mret updates take effect at the rising clk edge. The new value is visible on csr_rd_data and the exported outputs in the next cycle.
- Counter reads return the pre-increment value of the current cycle.
- The first cycle after reset deasserts reads mcycle = 0.
- reset going low mid-operation clears all state asynchronously. Outputs show reset values within the same cycle.
- Latency: read 0 cycles, write 1 cycle. No handshake; every access completes in one cycle.

## Test plan
- Reset check: release reset, then read 0x300, 0x305, 0x301.
  - Required: 32'h0000_1800, MTVEC_RESET, 32'h4000_0100.
  - mcycle reads 0, then 1 in the following cycle.
- Write/read with masking:
  - csrrw mscratch ← 32'hDEAD_BEEF: returns old value 0, next read returns DEAD_BEEF.
  - mtvec ← 32'h8000_0103: reads 32'h8000_0100.
- Counter carry and write override:
  - Write mcycle = 32'hFFFF_FFFF, mcycleh = 0.
  - Required: two cycles later mcycleh = 1 and mcycle = 1.
  - Writing minstret in a cycle with instr_retire=1 stores exactly the written value.
- Trap then mret:
  - MIE=1, trap with trap_pc = 32'h0000_0046, cause 2 → mepc = 32'h44, mcause = 2, MIE = 0, MPIE = 1.
  - mret → MIE = 1.
  - A CSR write to mepc in the trap cycle is ignored.
- Illegal access:
  - Read 0x7C0 → csr_rd_data = 0, csr_illegal = 1.
  - Write 0xC00 → csr_illegal = 1 and the cycle counter is unaffected.
  - mhartid = HART_ID.
- Asynchronous reset: pull reset low mid-cycle after writes → all CSRs return to reset values before the next clk edge.
